// File: rtl/ahb_lite_master_arb.sv
// Round-robin arbiter sharing one AHB-lite master port between NUM_REQ clients.
// Optional wait-state timeout enabled by defining AHB_TIMEOUT_EN.
module ahb_lite_master_arb #(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_W-1:0]         HADDR,
  output logic [DATA_W-1:0]         HWDATA,
  output logic                      HWRITE,
  output logic [1:0]                HTRANS,
  output logic                      HSEL,
  output logic                      HREADY,
  input  logic [DATA_W-1:0]         HRDATA,
  input  logic                      HREADYOUT,
  input  logic [1:0]                HRESP
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   owner;
  logic [DATA_W-1:0]  lat_wdata;
  logic [PTR_W-1:0]   winner;
  logic               found;
  logic [NUM_REQ-1:0] grant;
  logic               unused_bits;

`ifdef AHB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] wait_cnt;
`endif

  // Single-slave bus: the slave's ready is the bus ready.
  assign HREADY      = HREADYOUT;
  assign unused_bits = HRESP[1] ^ (TIMEOUT_CYC == 0);

  // Rotating priority search starting just after the last winner.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    grant = '0;
    if (found) grant[winner] = 1'b1;
  end

  assign req_ready = (state == S_IDLE && !HRESET) ? grant : '0;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= S_IDLE;
      rr_ptr    <= PTR_W'(NUM_REQ - 1);
      owner     <= '0;
      lat_wdata <= '0;
      HADDR     <= '0;
      HWDATA    <= '0;
      HWRITE    <= 1'b0;
      HTRANS    <= TRANS_IDLE;
      HSEL      <= 1'b0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef AHB_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      rsp_valid <= '0;
      case (state)
        S_IDLE: begin
          if (found) begin
            owner     <= winner;
            rr_ptr    <= winner;
            HWRITE    <= req_write[winner];
            HADDR     <= req_addr[int'(winner)*ADDR_W +: ADDR_W];
            lat_wdata <= req_wdata[int'(winner)*DATA_W +: DATA_W];
            HSEL      <= 1'b1;
            HTRANS    <= TRANS_NONSEQ;
            state     <= S_ADDR;
          end
        end
        S_ADDR: begin
          HSEL   <= 1'b0;
          HTRANS <= TRANS_IDLE;
          HWDATA <= lat_wdata;
          state  <= S_DATA;
`ifdef AHB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        S_DATA: begin
          if (HREADYOUT) begin
            rsp_valid[owner] <= 1'b1;
            rsp_rdata        <= HWRITE ? '0 : HRDATA;
            rsp_err          <= HRESP[0];
            state            <= S_IDLE;
          end
`ifdef AHB_TIMEOUT_EN
          // Completing on the edge where the count would reach the limit.
          else if (wait_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            rsp_valid[owner] <= 1'b1;
            rsp_rdata        <= '0;
            rsp_err          <= 1'b1;
            state            <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
